countdown_timer_59: RTL

- Loadable 00–59 seconds countdown timer: the down-counting counterpart of the existing 0–59 up-counting seconds display.
- Has an integrated 1 Hz prescaler, run/pause control and a terminal-count "done" event.
- Drives two active-low 7-segment digits (tens, ones) with the same segment ordering as the existing seconds display.
- Sits at board top level next to the up-counter, sharing the 50 MHz board clock.

---
 rtl/countdown_timer_59.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer_59.sv
// Loadable 00-59 seconds countdown timer with 1 Hz prescaler, run/pause and done event.
// Optional macro BLINK_DONE_EN: displays blink "00"/blank while in DONE.
module countdown_timer_59 #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] set_tens,
  input  logic [3:0] set_ones,
  input  logic       start_stop,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [0:6] seg_tens,
  output logic [0:6] seg_ones,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [3:0]    tens_next, ones_next, tens_dec, ones_dec;
  logic          presc_en, presc_wrap, tick, dec_zero, val_zero, done_pulse_next;
  logic          blank_next;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  assign presc_wrap = (presc == PW'(TICK_DIV - 1));
  assign tick       = (state == RUN) && presc_wrap;
  assign val_zero   = (tens == 4'd0) && (ones == 4'd0);

`ifdef BLINK_DONE_EN
  assign presc_en = (state == RUN) || (state == DONE);
`else
  assign presc_en = (state == RUN);
`endif

  always_comb begin
    tens_dec = tens;
    ones_dec = ones;
    if (ones != 4'd0) begin
      ones_dec = ones - 4'd1;
    end else if (tens != 4'd0) begin
      ones_dec = 4'd9;
      tens_dec = tens - 4'd1;
    end
    dec_zero = (tens_dec == 4'd0) && (ones_dec == 4'd0);
  end

  // Next-state logic; load overrides everything, reaching 00 beats a coincident pause
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop && !val_zero) state_next = RUN;
        RUN: begin
          if (tick && dec_zero) state_next = DONE;
          else if (start_stop)  state_next = PAUSE;
        end
        PAUSE:   if (start_stop) state_next = RUN;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
  end

  always_comb begin
    tens_next       = tens;
    ones_next       = ones;
    presc_next      = presc;
    done_pulse_next = 1'b0;
    if (load) begin
      tens_next  = (set_tens > 3'd5) ? 4'd5 : {1'b0, set_tens};
      ones_next  = (set_ones > 4'd9) ? 4'd9 : set_ones;
      presc_next = '0;
    end else begin
      if (presc_en) presc_next = presc_wrap ? '0 : presc + PW'(1);
      if (tick) begin
        tens_next       = tens_dec;
        ones_next       = ones_dec;
        done_pulse_next = dec_zero;
      end
    end
  end

`ifdef BLINK_DONE_EN
  // First half of each prescaler period shows "00"; DONE entry always lands on presc=0
  assign blank_next = (state_next == DONE) && (32'(presc_next) >= TICK_DIV / 2);
`else
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tens       <= '0;
      ones       <= '0;
      presc      <= '0;
      done_pulse <= 1'b0;
      seg_tens   <= 7'b0000001;
      seg_ones   <= 7'b0000001;
    end else begin
      tens       <= tens_next;
      ones       <= ones_next;
      presc      <= presc_next;
      done_pulse <= done_pulse_next;
      seg_tens   <= blank_next ? 7'b1111111 : seg7(tens_next);
      seg_ones   <= blank_next ? 7'b1111111 : seg7(ones_next);
    end
  end

endmodule
